display_mmio: RTL and testbench

- Memory-mapped I/O peripheral between the ARM processor data bus and the seven-segment display stage.
- Latches processor stores into the `num`/`letter` values that the display decoder consumes, with an optional freeze (double-buffer) mode.
- Synchronizes and debounces the 10 board switches and exposes them as read-only registers.
- Sits beside data memory; the processor reaches it with ordinary LDR/STR.

---
 rtl/display_mmio.sv | 194 +++++++++++++++++++
 tb/tb_display_mmio.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/display_mmio.sv
`default_nettype none
// ============================================================================
// Module   : display_mmio
// Purpose  : Memory-mapped display staging/output registers plus
//            synchronised, debounced board switches for the ARM data bus.
// Revision : 1.0  initial release
// ============================================================================
module display_mmio #(
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0C00,
    parameter int          DEBOUNCE_CYCLES = 50000,
    parameter int          CNT_W           = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        hit,
    input  logic [9:0]  switches,
    output logic [7:0]  num,
    output logic [3:0]  letter,
    output logic        disp_en
);

    localparam logic [2:0] c_off_num    = 3'd0;
    localparam logic [2:0] c_off_letter = 3'd1;
    localparam logic [2:0] c_off_ctrl   = 3'd2;
    localparam logic [2:0] c_off_sw     = 3'd3;
    localparam logic [2:0] c_off_status = 3'd4;

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_count = 1'b1;

    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Bus decode
    logic [2:0] w_off;
    logic       w_hit;
    logic       w_wr;
    logic       w_wr_num;
    logic       w_wr_letter;
    logic       w_wr_ctrl;
    logic       w_wr_status;

    assign w_off       = DataAdr[4:2];
    assign w_hit       = (DataAdr[31:5] == BASE_ADDR[31:5]) && (w_off <= c_off_status);
    assign w_wr        = MemWrite && w_hit;
    assign w_wr_num    = w_wr && (w_off == c_off_num);
    assign w_wr_letter = w_wr && (w_off == c_off_letter);
    assign w_wr_ctrl   = w_wr && (w_off == c_off_ctrl);
    assign w_wr_status = w_wr && (w_off == c_off_status);
    assign hit         = w_hit;

    // Staging and control registers
    logic [7:0] num_stage_q;
    logic [3:0] letter_stage_q;
    logic [1:0] ctrl_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            num_stage_q    <= '0;
            letter_stage_q <= '0;
            ctrl_q         <= '0;
        end else begin
            if (w_wr_num)    num_stage_q    <= WriteData[7:0];
            if (w_wr_letter) letter_stage_q <= WriteData[3:0];
            if (w_wr_ctrl)   ctrl_q         <= WriteData[1:0];
        end
    end

    // Output stage: frozen outputs hold, otherwise track staging one cycle late
    logic [7:0] num_q;
    logic [3:0] letter_q;
    logic       disp_en_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            num_q     <= '0;
            letter_q  <= '0;
            disp_en_q <= 1'b1;
        end else begin
            if (!ctrl_q[0]) begin
                num_q    <= num_stage_q;
                letter_q <= letter_stage_q;
            end
            disp_en_q <= ~ctrl_q[1];
        end
    end

    assign num     = num_q;
    assign letter  = letter_q;
    assign disp_en = disp_en_q;

    // Switch synchroniser
    logic [9:0] sync1_q;
    logic [9:0] sync2_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= switches;
            sync2_q <= sync1_q;
        end
    end

    // Debounce FSM
    logic [0:0]       state_q, state_d;
    logic [9:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       sw_db_q, sw_db_d;
    logic             sw_chg_q, sw_chg_d;
    logic             w_commit;

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        sw_db_d  = sw_db_q;
        w_commit = 1'b0;
        case (state_q)
            c_st_idle: begin
                if (sync2_q != sw_db_q) begin
                    cand_d  = sync2_q;
                    cnt_d   = '0;
                    state_d = c_st_count;
                end
            end
            c_st_count: begin
                if (sync2_q == sw_db_q) begin
                    state_d = c_st_idle;
                end else if (sync2_q != cand_q) begin
                    cand_d = sync2_q;
                    cnt_d  = '0;
                end else if (cnt_q == c_cnt_max) begin
                    sw_db_d  = cand_q;
                    w_commit = 1'b1;
                    state_d  = c_st_idle;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = c_st_idle;
        endcase
    end

    // A commit in the same cycle as a clearing write keeps the flag set
    always_comb begin
        sw_chg_d = sw_chg_q;
        if (w_commit) begin
            sw_chg_d = 1'b1;
        end else if (w_wr_status && WriteData[0]) begin
            sw_chg_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= c_st_idle;
            cand_q   <= '0;
            cnt_q    <= '0;
            sw_db_q  <= '0;
            sw_chg_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            sw_db_q  <= sw_db_d;
            sw_chg_q <= sw_chg_d;
        end
    end

    // Zero-wait-state read mux
    always_comb begin
        ReadData = '0;
        if (w_hit) begin
            case (w_off)
                c_off_num:    ReadData = {24'b0, num_stage_q};
                c_off_letter: ReadData = {28'b0, letter_stage_q};
                c_off_ctrl:   ReadData = {30'b0, ctrl_q};
                c_off_sw:     ReadData = {22'b0, sw_db_q};
                c_off_status: ReadData = {31'b0, sw_chg_q};
                default:      ReadData = '0;
            endcase
        end
    end

    logic w_unused_ok;
    assign w_unused_ok = ^{DataAdr[1:0], WriteData[31:8]};

endmodule
`default_nettype wire

// File: tb/tb_display_mmio.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_mmio
// Purpose  : Self-checking bench for display_mmio against a run-length model.
// Revision : 1.0  initial release
// ============================================================================
module tb_display_mmio;

    localparam logic [31:0] BASE = 32'h0000_0C00;
    localparam int          DEB  = 4;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        hit;
    logic [9:0]  switches;
    logic [7:0]  num;
    logic [3:0]  letter;
    logic        disp_en;

    int n_checks = 0;
    int n_fail   = 0;

    display_mmio #(
        .BASE_ADDR      (BASE),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (8)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .MemWrite (MemWrite),
        .DataAdr  (DataAdr),
        .WriteData(WriteData),
        .ReadData (ReadData),
        .hit      (hit),
        .switches (switches),
        .num      (num),
        .letter   (letter),
        .disp_en  (disp_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a switch value commits once the synchronised input has
    // held a new value for DEB+1 consecutive samples.
    logic [7:0] m_stage_num, m_num;
    logic [3:0] m_stage_let, m_letter;
    logic       m_freeze, m_blank, m_disp_en, m_sw_chg;
    logic [9:0] m_s1, m_s2, m_prev, m_db;
    int         m_run;
    int         m_run_n;
    bit         m_commit;

    assign m_run_n  = (m_s2 == m_prev) ? m_run + 1 : 1;
    assign m_commit = (m_s2 != m_db) && (m_run_n >= DEB + 1);

    function automatic bit m_hit(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'd20);
    endfunction

    function automatic logic [31:0] m_rd(input logic [31:0] a);
        case ((a - BASE) >> 2)
            0: return {24'b0, m_stage_num};
            1: return {28'b0, m_stage_let};
            2: return {30'b0, m_blank, m_freeze};
            3: return {22'b0, m_db};
            4: return {31'b0, m_sw_chg};
            default: return 32'b0;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_stage_num <= '0; m_stage_let <= '0; m_freeze <= 1'b0; m_blank <= 1'b0;
            m_num <= '0; m_letter <= '0; m_disp_en <= 1'b1; m_sw_chg <= 1'b0;
            m_s1 <= '0; m_s2 <= '0; m_prev <= '0; m_db <= '0; m_run <= 0;
        end else begin
            m_s1   <= switches;
            m_s2   <= m_s1;
            m_prev <= m_s2;
            m_run  <= m_run_n;
            if (m_commit) m_db <= m_s2;
            if (!m_freeze) begin
                m_num    <= m_stage_num;
                m_letter <= m_stage_let;
            end
            m_disp_en <= !m_blank;
            if (MemWrite && m_hit(DataAdr)) begin
                case ((DataAdr - BASE) >> 2)
                    0: m_stage_num <= WriteData[7:0];
                    1: m_stage_let <= WriteData[3:0];
                    2: {m_blank, m_freeze} <= WriteData[1:0];
                    4: if (WriteData[0]) m_sw_chg <= 1'b0;
                    default: ;
                endcase
            end
            if (m_commit) m_sw_chg <= 1'b1;
        end
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check_value("num", {24'b0, num}, {24'b0, m_num});
        check_value("letter", {28'b0, letter}, {28'b0, m_letter});
        check_value("disp_en", {31'b0, disp_en}, {31'b0, m_disp_en});
    endtask

    task automatic rd_check(input string tag, input logic [31:0] a);
        MemWrite = 1'b0;
        DataAdr  = a;
        #1;
        check_value({tag, "_hit"}, {31'b0, hit}, {31'b0, m_hit(a)});
        if (m_hit(a)) check_value(tag, ReadData, m_rd(a));
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        MemWrite  = 1'b1;
        DataAdr   = a;
        WriteData = d;
        step();
        MemWrite  = 1'b0;
    endtask

    logic [9:0]  sw_pick [4];
    logic [31:0] ra;

    initial begin
        reset = 1'b0; MemWrite = 1'b0; DataAdr = '0; WriteData = '0; switches = '0;
        sw_pick[0] = 10'd0; sw_pick[1] = 10'd4; sw_pick[2] = 10'h3FF; sw_pick[3] = 10'h155;
        repeat (3) step();
        check_value("rst_num", {24'b0, num}, 32'h0);
        check_value("rst_letter", {28'b0, letter}, 32'h0);
        check_value("rst_disp_en", {31'b0, disp_en}, 32'h1);
        #2 reset = 1'b1;
        step();
        DataAdr = 32'hC0C; #1;
        check_value("rst_sw_read", ReadData, 32'h0);
        DataAdr = 32'hC00; #1;
        check_value("hit_c00", {31'b0, hit}, 32'h1);
        DataAdr = 32'hC14; #1;
        check_value("hit_c14", {31'b0, hit}, 32'h0);
        DataAdr = 32'hBFC; #1;
        check_value("hit_bfc", {31'b0, hit}, 32'h0);

        // Store path and one-cycle latency
        bus_write(32'hC00, 32'h5A);
        step();
        check_value("num_5a", {24'b0, num}, 32'h5A);
        bus_write(32'hC04, 32'h3);
        step();
        check_value("letter_3", {28'b0, letter}, 32'h3);
        DataAdr = 32'hC00; #1;
        check_value("ldr_c00", ReadData, 32'h5A);

        // Freeze then atomic release
        bus_write(32'hC08, 32'h1);
        bus_write(32'hC00, 32'h11);
        step();
        check_value("frozen_num", {24'b0, num}, 32'h5A);
        DataAdr = 32'hC00; #1;
        check_value("frozen_stage", ReadData, 32'h11);
        bus_write(32'hC08, 32'h0);
        step();
        check_value("unfrozen_num", {24'b0, num}, 32'h11);

        // Stable switch change: commit 2+1+DEB edges after the input change
        switches = 10'd4;
        repeat (6) step();
        DataAdr = 32'hC0C; #1;
        check_value("sw_early", ReadData, 32'h0);
        step();
        DataAdr = 32'hC0C; #1;
        check_value("sw_commit", ReadData, 32'h4);
        DataAdr = 32'hC10; #1;
        check_value("status_set", ReadData, 32'h1);
        bus_write(32'hC10, 32'h1);
        DataAdr = 32'hC10; #1;
        check_value("status_clr", ReadData, 32'h0);

        // Return to 0, then a too-short pulse must be rejected
        switches = 10'd0;
        repeat (10) step();
        bus_write(32'hC10, 32'h1);
        switches = 10'd4;
        repeat (3) step();
        switches = 10'd0;
        repeat (10) step();
        DataAdr = 32'hC0C; #1;
        check_value("pulse_sw", ReadData, 32'h0);
        DataAdr = 32'hC10; #1;
        check_value("pulse_status", ReadData, 32'h0);

        // Blank, then asynchronous reset in the middle of a debounce
        bus_write(32'hC08, 32'h2);
        step();
        check_value("blank_disp_en", {31'b0, disp_en}, 32'h0);
        check_value("blank_num", {24'b0, num}, 32'h11);
        switches = 10'd4;
        repeat (4) step();
        #2 reset = 1'b0;
        #1;
        check_value("mid_rst_disp_en", {31'b0, disp_en}, 32'h1);
        DataAdr = 32'hC0C; #1;
        check_value("mid_rst_sw", ReadData, 32'h0);
        reset = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            rd_check("post_rst_sw", 32'hC0C);
        end

        // Randomised bus and switch traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) switches = sw_pick[$urandom_range(0, 3)];
            if ($urandom_range(0, 7) == 0) ra = $urandom;
            else ra = BASE + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
            rd_check("rand_rd", ra);
            if ($urandom_range(0, 1) == 0) begin
                MemWrite  = 1'b1;
                WriteData = $urandom;
            end
            step();
            MemWrite = 1'b0;
        end
        rd_check("final_sw", 32'hC0C);
        rd_check("final_status", 32'hC10);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
